rvarb2_pipe_ctl: RTL and testbench
==================================

Name: rvarb2_pipe_ctl

Overview:
- Two-requester, packet-atomic round-robin arbiter feeding one shared pipeline register stage of WIDTH bits: 32b payload plus 6b tag at the default of 38.
- Sequences accept/hold/drain of the shared stage with valid/ready handshakes on both sides.
- Sits between two producers (e.g. two LSU/IFU request sources) and a single downstream consumer.
- Stage flops reset to zero asynchronously on rst_l low.

Parameters:
- WIDTH, 38, payload width of each requester and of the output stage.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_l  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has a beat.
- req0_data  in  WIDTH  requester 0 beat.
- req0_last  in  1  beat ends requester 0 packet.
- req0_ready  out  1  requester 0 beat accepted this cycle.
- req1_valid  in  1  requester 1 has a beat.
- req1_data  in  WIDTH  requester 1 beat.
- req1_last  in  1  beat ends requester 1 packet.
- req1_ready  out  1  requester 1 beat accepted this cycle.
- out_valid  out  1  stage holds a beat.
- out_data  out  WIDTH  stage contents.
- out_src  out  1  requester id of stage contents.
- out_last  out  1  last flag of stage contents.
- out_ready  in  1  consumer takes stage contents this cycle.
- busy  out  1  state != IDLE or out_valid.

Behaviour:
- Interface: one clock (clk); reset rst_l is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_src=0, out_last=0, rr_ptr=0 (req0 preferred), state=IDLE. req*_ready are combinational and therefore 0 while out stage is empty with no valid requests.
- Reset mid-operation clears stage and lock immediately; an in-flight beat is dropped and no ready is asserted while rst_l=0.
- Handshake rules (producer): must hold valid/data/last stable until ready; transfer occurs when valid&ready in the same cycle.
- Handshake rules (consumer): transfer when out_valid&out_ready.
- load_en = ~out_valid | out_ready. Stage refills in the same cycle it drains, giving full throughput of 1 beat/cycle and latency of 1 cycle from accept to out_valid.
- grant (combinational) by state:
  - IDLE: only one valid -> that one; both valid -> rr_ptr; none -> no grant.
  - LOCK0: grant req0 only. If req0_valid=0, bubble; req1 is never granted in LOCK0.
  - LOCK1: symmetric to LOCK0.
- reqN_ready = load_en & grant==N & reqN_valid.
- On accept from N: stage loads {data, last}, out_src=N, out_valid=1.
- State transitions on accept from N:
  - last=0 -> state=LOCKN.
  - last=1 -> state=IDLE, rr_ptr=~N.
- Drain with no accept: out_valid=0; out_data holds its old value (no clear).
- No accept in a cycle: state and rr_ptr unchanged.
- Simultaneous drain+accept: new beat visible next cycle, out_valid stays 1.
- Single-beat packets (last=1) from both requesters alternate strictly when both are continuously valid.
- out_ready asserted while out_valid=0 is ignored.
- Assertions:
  - No ready to both requesters in the same cycle.
  - out_data stable while out_valid&~out_ready.
  - Never a grant to N̄ while in LOCKN.

Decomposition:
- Shared package rvarb_pkg holds:
  - state enum {IDLE, LOCK0, LOCK1} (2 bits).
  - Constant ARB_REQ0=1'b0, ARB_REQ1=1'b1.
  - Default width constant 38.
- One sub-module, rvarb2_stage: WIDTH+2 bit enabled pipeline register with async active-low clear. Holds data, last and src; out_valid is kept in the parent.
- Grant/FSM logic lives in the parent.

Test Plan:
- Reset: drive rst_l=0 with both valids high -> out_valid=0, out_data=0, ready=0 both; release -> first accept goes to req0 (rr_ptr=0).
- Alternation: both valid, last=1 every beat, out_ready=1 -> out_src sequence 0,1,0,1; one beat per cycle; data 38'h00_0000_0001 appears on out_data one cycle after accept.
- Packet lock: req0 sends a 3-beat packet (last on beat 3), req1 valid throughout -> three req0 beats contiguous, then req1 granted; req1_ready=0 for those 3 cycles.
- Lock bubble: in LOCK1, req1_valid drops for 2 cycles while req0 valid -> no accepts, out_valid falls after drain; resumes with req1, not req0.
- Backpressure: out_ready=0 for 4 cycles with stage full -> both readys=0, out_data stable; out_ready=1 -> drain and refill in the same cycle.
- Reset mid-packet: assert rst_l=0 in LOCK0 -> state=IDLE, stage cleared; after release, req1 with rr_ptr=0 and only req1 valid is granted immediately.

Source files
------------

// File: rtl/rvarb_pkg.sv
// Shared types and constants for the two-requester packet arbiter.
package rvarb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam logic ARB_REQ0 = 1'b0;
    localparam logic ARB_REQ1 = 1'b1;

    localparam int RVARB_WIDTH = 38;

endpackage

// File: rtl/rvarb2_stage.sv
// Enabled pipeline register with asynchronous active-low clear.
module rvarb2_stage #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rvarb2_pipe_ctl.sv
// Packet-atomic round-robin arbiter for two producers into one
// shared pipeline stage.
module rvarb2_pipe_ctl
    import rvarb_pkg::*;
#(
    parameter int WIDTH = RVARB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    arb_state_e       state;
    logic             rr_ptr;
    logic             load_en;
    logic             gnt_vld;
    logic             gnt_id;
    logic             accept;
    logic             acc_id;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;

    assign load_en = ~out_valid | out_ready;

    // A locked packet owner keeps the grant even while it bubbles.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = ARB_REQ0;
        case (state)
            LOCK0: begin
                gnt_vld = 1'b1;
                gnt_id  = ARB_REQ0;
            end
            LOCK1: begin
                gnt_vld = 1'b1;
                gnt_id  = ARB_REQ1;
            end
            default: begin
                gnt_vld = req0_valid | req1_valid;
                if (req0_valid & req1_valid) begin
                    gnt_id = rr_ptr;
                end else begin
                    gnt_id = req1_valid ? ARB_REQ1 : ARB_REQ0;
                end
            end
        endcase
    end

    assign req0_ready = rst_l & load_en & gnt_vld
                      & (gnt_id == ARB_REQ0) & req0_valid;
    assign req1_ready = rst_l & load_en & gnt_vld
                      & (gnt_id == ARB_REQ1) & req1_valid;

    assign accept   = req0_ready | req1_ready;
    assign acc_id   = req1_ready ? ARB_REQ1 : ARB_REQ0;
    assign acc_last = req1_ready ? req1_last : req0_last;
    assign acc_data = req1_ready ? req1_data : req0_data;

    rvarb2_stage #(
        .W (WIDTH + 2)
    ) u_stage (
        .clk   (clk),
        .rst_l (rst_l),
        .en    (accept),
        .d     ({acc_data, acc_last, acc_id}),
        .q     ({out_data, out_last, out_src})
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            rr_ptr    <= ARB_REQ0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                if (acc_last) begin
                    state  <= IDLE;
                    rr_ptr <= ~acc_id;
                end else begin
                    state <= acc_id ? LOCK1 : LOCK0;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE) | out_valid;

`ifndef SYNTHESIS
    a_one_ready : assert property (@(posedge clk) disable iff (!rst_l)
        !(req0_ready && req1_ready));
    a_hold_data : assert property (@(posedge clk) disable iff (!rst_l)
        (out_valid && !out_ready) |=> $stable(out_data));
    a_lock_gnt : assert property (@(posedge clk) disable iff (!rst_l)
        !((state == LOCK0) && req1_ready) && !((state == LOCK1) && req0_ready));
`endif

endmodule

// File: tb/tb_rvarb2_pipe_ctl.sv
// Self-checking bench for rvarb2_pipe_ctl against a packet-level
// arbitration model.
module tb_rvarb2_pipe_ctl;

    localparam int W = 38;

    logic         clk = 1'b0;
    logic         rst_l;
    logic         v0, v1, l0, l1, ordy;
    logic [W-1:0] d0, d1;
    logic         r0, r1;
    logic         out_valid, out_src, out_last, busy;
    logic [W-1:0] out_data;

    int total = 0;
    int bad = 0;

    int           m_owner;
    bit           m_pref, m_ov, m_src, m_last;
    logic [W-1:0] m_data;
    bit           acc0, acc1;

    always #5 clk = ~clk;

    rvarb2_pipe_ctl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .req0_valid (v0),
        .req0_data  (d0),
        .req0_last  (l0),
        .req0_ready (r0),
        .req1_valid (v1),
        .req1_data  (d1),
        .req1_last  (l1),
        .req1_ready (r1),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_last   (out_last),
        .out_ready  (ordy),
        .busy       (busy)
    );

    function automatic logic [W-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Who may move a beat now: the packet owner if one is open,
    // else whoever is waiting, with ties going to the preferred side.
    function automatic void exp_ready(output bit e0, output bit e1);
        int  cand;
        bit  room;
        room = !m_ov || ordy;
        cand = -1;
        if (m_owner >= 0) begin
            if ((m_owner == 0 && v0) || (m_owner == 1 && v1))
                cand = m_owner;
        end else if (v0 && v1) begin
            cand = m_pref ? 1 : 0;
        end else if (v0) begin
            cand = 0;
        end else if (v1) begin
            cand = 1;
        end
        e0 = rst_l && room && cand == 0;
        e1 = rst_l && room && cand == 1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_pref  = 1'b0;
        m_ov    = 1'b0;
        m_src   = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        acc0    = 1'b0;
        acc1    = 1'b0;
    endtask

    task automatic tick();
        bit e0, e1;
        exp_ready(e0, e1);
        @(posedge clk);
        acc0 = e0;
        acc1 = e1;
        if (e0 || e1) begin
            m_ov   = 1'b1;
            m_src  = e1;
            m_data = e1 ? d1 : d0;
            m_last = e1 ? l1 : l0;
            if (m_last) begin
                m_owner = -1;
                m_pref  = !e1;
            end else begin
                m_owner = e1 ? 1 : 0;
            end
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        #1;
        if (acc0) d0 = rnd_data();
        if (acc1) d1 = rnd_data();
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        v0 = 1'b1; v1 = 1'b1; l0 = 1'b1; l1 = 1'b1; ordy = 1'b1;
        d0 = rnd_data(); d1 = rnd_data();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_src, out_last, out_data, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b s=%b l=%b d=%h busy=%b want all 0",
                     out_valid, out_src, out_last, out_data, busy);
        end
        total++;
        if ({r0, r1} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: got %b%b want 00", r0, r1);
        end
        rst_l = 1'b1;
        #1;
        total++;
        if ({r0, r1} !== 2'b10) begin
            bad++;
            $display("FAIL reset_first_grant: got %b%b want 10", r0, r1);
        end
        v0 = 1'b0; v1 = 1'b0;
        tick();
    endtask

    task automatic test_alternation();
        bit e0, e1;
        d0 = 38'h00_0000_0001;
        v0 = 1'b1; v1 = 1'b1; l0 = 1'b1; l1 = 1'b1; ordy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_ready(e0, e1);
            total++;
            if ({r0, r1} !== {e0, e1} || r0 !== (i % 2 == 0)) begin
                bad++;
                $display("FAIL alt_ready[%0d]: got %b%b want %b%b", i, r0, r1, e0, e1);
            end
            tick();
            total++;
            if ({out_valid, out_src, out_last, out_data} !== {m_ov, m_src, m_last, m_data}
                || out_src !== 1'(i % 2)) begin
                bad++;
                $display("FAIL alt_out[%0d]: got v=%b s=%b d=%h want v=%b s=%b d=%h",
                         i, out_valid, out_src, out_data, m_ov, m_src, m_data);
            end
            if (i == 0) begin
                total++;
                if (out_data !== 38'h00_0000_0001) begin
                    bad++;
                    $display("FAIL alt_first_data: got %h want 0000000001", out_data);
                end
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_packet_lock();
        v0 = 1'b1; v1 = 1'b1; l1 = 1'b1; ordy = 1'b1;
        for (int b = 0; b < 3; b++) begin
            l0 = (b == 2);
            #1;
            total++;
            if ({r0, r1} !== 2'b10) begin
                bad++;
                $display("FAIL lock_beat[%0d]: got %b%b want 10", b, r0, r1);
            end
            tick();
            total++;
            if ({out_valid, out_src, out_last, out_data} !== {m_ov, m_src, m_last, m_data}) begin
                bad++;
                $display("FAIL lock_out[%0d]: got s=%b l=%b d=%h want s=%b l=%b d=%h",
                         b, out_src, out_last, out_data, m_src, m_last, m_data);
            end
        end
        #1;
        total++;
        if ({r0, r1} !== 2'b01) begin
            bad++;
            $display("FAIL lock_release: got %b%b want 01", r0, r1);
        end
        tick();
        v0 = 1'b0; v1 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_lock_bubble();
        v0 = 1'b0; v1 = 1'b1; l1 = 1'b0; ordy = 1'b1;
        #1;
        total++;
        if ({r0, r1} !== 2'b01) begin
            bad++;
            $display("FAIL bubble_open: got %b%b want 01", r0, r1);
        end
        tick();
        v1 = 1'b0; v0 = 1'b1; l0 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({r0, r1} !== 2'b00) begin
                bad++;
                $display("FAIL bubble_ready[%0d]: got %b%b want 00", c, r0, r1);
            end
            tick();
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bubble_drain[%0d]: got v=%b busy=%b want v=0 busy=1",
                         c, out_valid, busy);
            end
        end
        v1 = 1'b1; l1 = 1'b1;
        #1;
        total++;
        if ({r0, r1} !== 2'b01) begin
            bad++;
            $display("FAIL bubble_resume: got %b%b want 01", r0, r1);
        end
        tick();
        v1 = 1'b0;
        #1;
        total++;
        if ({r0, r1} !== 2'b10) begin
            bad++;
            $display("FAIL bubble_after: got %b%b want 10", r0, r1);
        end
        tick();
        v0 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        bit e0, e1;
        v0 = 1'b1; v1 = 1'b1; l0 = 1'b1; l1 = 1'b1; ordy = 1'b1;
        tick();
        ordy = 1'b0;
        held = out_data;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if ({r0, r1} !== 2'b00) begin
                bad++;
                $display("FAIL bp_ready[%0d]: got %b%b want 00", c, r0, r1);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== held) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=%h",
                         c, out_valid, out_data, held);
            end
        end
        ordy = 1'b1;
        #1;
        exp_ready(e0, e1);
        total++;
        if ({r0, r1} !== {e0, e1} || (r0 | r1) !== 1'b1) begin
            bad++;
            $display("FAIL bp_refill_ready: got %b%b want %b%b", r0, r1, e0, e1);
        end
        tick();
        total++;
        if ({out_valid, out_src, out_data} !== {1'b1, m_src, m_data} || out_data === held) begin
            bad++;
            $display("FAIL bp_refill_out: got v=%b s=%b d=%h want v=1 s=%b d=%h",
                     out_valid, out_src, out_data, m_src, m_data);
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_packet();
        v0 = 1'b1; v1 = 1'b1; l0 = 1'b0; l1 = 1'b1; ordy = 1'b0;
        m_pref = 1'b0;
        // force the preference to req0 by resetting first
        rst_l = 1'b0;
        #1;
        model_reset();
        rst_l = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        ordy = 1'b1;
        v1 = 1'b0;
        tick();
        v1 = 1'b1;
        #1;
        total++;
        if ({r0, r1, busy} !== 3'b101) begin
            bad++;
            $display("FAIL midrst_lock0: got r=%b%b busy=%b want r=10 busy=1", r0, r1, busy);
        end
        rst_l = 1'b0;
        #1;
        total++;
        if ({out_valid, out_data, r0, r1, busy} !== '0) begin
            bad++;
            $display("FAIL midrst_clear: got v=%b d=%h r=%b%b busy=%b want all 0",
                     out_valid, out_data, r0, r1, busy);
        end
        model_reset();
        #2;
        rst_l = 1'b1;
        v0 = 1'b0;
        #1;
        total++;
        if ({r0, r1} !== 2'b01) begin
            bad++;
            $display("FAIL midrst_req1: got %b%b want 01", r0, r1);
        end
        tick();
        total++;
        if ({out_valid, out_src, out_data} !== {1'b1, 1'b1, m_data}) begin
            bad++;
            $display("FAIL midrst_out: got v=%b s=%b d=%h want v=1 s=1 d=%h",
                     out_valid, out_src, out_data, m_data);
        end
        v1 = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        bit e0, e1;
        for (int c = 0; c < 400; c++) begin
            if (!v0 && ($urandom % 4 != 0)) begin
                v0 = 1'b1; d0 = rnd_data(); l0 = ($urandom % 3 == 0);
            end
            if (!v1 && ($urandom % 4 != 0)) begin
                v1 = 1'b1; d1 = rnd_data(); l1 = ($urandom % 3 == 0);
            end
            ordy = ($urandom % 4 != 0);
            #1;
            exp_ready(e0, e1);
            total++;
            if ({r0, r1} !== {e0, e1}) begin
                bad++;
                $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", c, r0, r1, e0, e1);
            end
            tick();
            if (acc0) v0 = 1'b0;
            if (acc1) v1 = 1'b0;
            total++;
            if ({out_valid, out_src, out_last, out_data, busy}
                !== {m_ov, m_src, m_last, m_data, (m_owner >= 0) || m_ov}) begin
                bad++;
                $display("FAIL rnd_out[%0d]: got v=%b s=%b l=%b d=%h b=%b want v=%b s=%b l=%b d=%h",
                         c, out_valid, out_src, out_last, out_data, busy,
                         m_ov, m_src, m_last, m_data);
            end
        end
        v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_alternation();
        test_packet_lock();
        test_lock_bubble();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
